uart_tx: RTL

8-bit UART transmitter, the transmit-side companion to the team's UART receiver.
- Accepts one byte per valid/ready handshake.
- Serialises it LSB-first as start bit, 8 data bits, optional parity, then 1 or 2 stop bits.
- Drives an idle-high serial line.
- Default bit period matches the receiver's 868-clock bit time at the system clock.

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with optional parity and 1/2 stop bits
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  // Illegal PARITY / STOP_BITS values fall back to no parity / one stop bit.
  localparam bit       PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam logic     PAR_ODD = (PARITY == 2);
  localparam int       NSTOP   = (STOP_BITS == 2) ? 2 : 1;
  localparam int       CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic          LAST_STOP = 1'(NSTOP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            par_bit;
  logic            stop_idx;
  logic            bit_end;

  // A line level ends on the edge where the counter reaches its last value.
  assign bit_end = (cnt == LAST_CNT);

  // Frame sequencer: every output is a register updated alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      stop_idx    <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_ready  <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_tx_valid) begin
            shift       <= i_tx_byte;
            par_bit     <= (^i_tx_byte) ^ PAR_ODD;
            idx         <= '0;
            stop_idx    <= 1'b0;
            state       <= S_START;
            o_tx_serial <= 1'b0;
            o_tx_ready  <= 1'b0;
            o_tx_active <= 1'b1;
          end
        end

        S_START: begin
          if (!bit_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt         <= '0;
            idx         <= '0;
            state       <= S_DATA;
            o_tx_serial <= shift[0];
          end
        end

        S_DATA: begin
          if (!bit_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (idx != 3'd7) begin
              // Shift right so the next LSB-first bit always sits in shift[1].
              idx         <= idx + 1'b1;
              shift       <= {1'b0, shift[7:1]};
              o_tx_serial <= shift[1];
            end else if (PAR_EN) begin
              state       <= S_PARITY;
              o_tx_serial <= par_bit;
            end else begin
              state       <= S_STOP;
              stop_idx    <= 1'b0;
              o_tx_serial <= 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (!bit_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt         <= '0;
            stop_idx    <= 1'b0;
            state       <= S_STOP;
            o_tx_serial <= 1'b1;
          end
        end

        S_STOP: begin
          o_tx_serial <= 1'b1;
          if (!bit_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              // Returning to IDLE here forces one idle-high cycle before the next start bit.
              state       <= S_IDLE;
              o_tx_ready  <= 1'b1;
              o_tx_active <= 1'b0;
              o_tx_done   <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          o_tx_serial <= 1'b1;
          o_tx_ready  <= 1'b1;
          o_tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
